// File: rtl/cpu_datapath.sv
// Execution datapath of the 16-bit processor: register file, PC, IR, ALU and
// the memory-address / write-back muxes steered by the control unit's control word.
module cpu_datapath #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned AW       = 16,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        write_add,
  input  logic [2:0]        fir_add,
  input  logic [2:0]        sec_add,
  input  logic              add_sel,
  input  logic              mux_sel,
  input  logic              pc_id,
  input  logic              pc_inc,
  input  logic              pc_sel,
  input  logic              ir_id,
  input  logic              mem_wr,
  input  logic              reg_wr,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] IR,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG = 8;
  localparam int unsigned XW   = DATA_W + 1;
  localparam int unsigned MW   = 2 * DATA_W;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [DATA_W-1:0] a, b, alu_res, wb_data;
  logic              alu_c;
  logic [XW-1:0]     ext_sum;
  logic [MW-1:0]     mul_full;

  assign a         = rf_q[fir_add];
  assign b         = rf_q[sec_add];
  assign mem_addr  = add_sel ? AW'(a) : pc_q;
  assign mem_wdata = b;
  assign mem_we    = mem_wr;
  assign dbg_data  = rf_q[dbg_sel];
  assign IR        = ir_q;
  assign mul_full  = MW'(a) * MW'(b);

  // ALU: one extra sum bit carries the carry-out, or the borrow for subtraction
  always_comb begin
    alu_res = a;
    alu_c   = 1'b0;
    ext_sum = '0;
    case (opcode)
      OP_ADD: begin
        ext_sum = XW'(a) + XW'(b);
        alu_res = ext_sum[DATA_W-1:0];
        alu_c   = ext_sum[DATA_W];
      end
      OP_SUB: begin
        ext_sum = XW'(a) - XW'(b);
        alu_res = ext_sum[DATA_W-1:0];
        alu_c   = ext_sum[DATA_W];
      end
      OP_MUL: begin
        alu_res = mul_full[DATA_W-1:0];
        alu_c   = |mul_full[MW-1:DATA_W];
      end
      OP_DIV: begin
        if (b == '0) begin
          alu_res = '1;
          alu_c   = 1'b1;
        end else begin
          alu_res = a / b;
        end
      end
      OP_INC: begin
        ext_sum = XW'(a) + XW'(1);
        alu_res = ext_sum[DATA_W-1:0];
        alu_c   = ext_sum[DATA_W];
      end
      OP_DEC: begin
        ext_sum = XW'(a) - XW'(1);
        alu_res = ext_sum[DATA_W-1:0];
        alu_c   = ext_sum[DATA_W];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      default: alu_res = a;
    endcase
  end

  assign N = alu_res[DATA_W-1];
  assign Z = (alu_res == '0);
  assign C = alu_c;

  // Next state of register file, PC and IR; reset overrides every enable
  always_comb begin
    wb_data = mux_sel ? mem_rdata : alu_res;
    rf_d    = rf_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (reg_wr) rf_d[write_add] = wb_data;
    if (pc_id) begin
      pc_d = pc_sel ? AW'(b) : pc_q + AW'(1);
    end else if (pc_inc) begin
      pc_d = pc_q + AW'(1);
    end
    if (ir_id) ir_d = mem_rdata;
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_d[i] = '0;
      pc_d = PC_RESET;
      ir_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    rf_q <= rf_d;
    pc_q <= pc_d;
    ir_q <= ir_d;
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: an arithmetic reference model predicts each
// cycle's observable outputs; a negedge monitor pops and compares them.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  write_add, fir_add, sec_add, dbg_sel;
  logic        add_sel, mux_sel, pc_id, pc_inc, pc_sel, ir_id, mem_wr, reg_wr;
  logic [3:0]  opcode;
  logic [15:0] IR, mem_addr, mem_wdata, mem_rdata, dbg_data;
  logic        N, Z, C, mem_we;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .rst(rst), .write_add(write_add), .fir_add(fir_add), .sec_add(sec_add),
    .add_sel(add_sel), .mux_sel(mux_sel), .pc_id(pc_id), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_id(ir_id), .mem_wr(mem_wr), .reg_wr(reg_wr), .opcode(opcode), .IR(IR),
    .N(N), .Z(Z), .C(C), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // External unified memory: asynchronous read, synchronous write
  logic [15:0] mem [65536];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic       rst;
    logic [2:0] wa, fa, sa, dbg;
    logic       add_sel, mux_sel, pc_id, pc_inc, pc_sel, ir_id, mem_wr, reg_wr;
    logic [3:0] op;
  } ctl_t;

  typedef struct {
    logic [15:0] ir, addr, wdata, dbg;
    logic        n, z, c, we;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int unsigned m_rf [8];
  int unsigned m_pc, m_ir;
  int unsigned m_mem [65536];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("IR",        IR,                 e.ir);
      check("mem_addr",  mem_addr,           e.addr);
      check("mem_wdata", mem_wdata,          e.wdata);
      check("mem_we",    16'(mem_we),        16'(e.we));
      check("dbg_data",  dbg_data,           e.dbg);
      check("flag_N",    16'(N),             16'(e.n));
      check("flag_Z",    16'(Z),             16'(e.z));
      check("flag_C",    16'(C),             16'(e.c));
    end
  end

  function automatic void alu_model(input int unsigned a, input int unsigned b, input int unsigned op,
                                    output int unsigned res, output bit c);
    longint unsigned p;
    res = a;
    c   = 1'b0;
    case (op)
      0: begin res = (a + b) % 65536; c = (a + b) > 65535; end
      1: begin res = (a + 65536 - b) % 65536; c = (a < b); end
      2: begin p = 64'(a) * 64'(b); res = int'(p % 65536); c = (p > 65535); end
      3: if (b == 0) begin res = 65535; c = 1'b1; end else res = a / b;
      4: begin res = (a + 1) % 65536; c = (a == 65535); end
      5: begin res = (a + 65535) % 65536; c = (a == 0); end
      6: res = a & b;
      7: res = a | b;
      8: res = a ^ b;
      9: res = 65535 - a;
      default: res = a;
    endcase
  endfunction

  // Drive one control word, predict this cycle's outputs, advance the model over the edge
  task automatic cycle(input ctl_t k, input bit chk);
    int unsigned a, b, res, addr, rdata;
    bit          c;
    exp_t        e;
    rst = k.rst; write_add = k.wa; fir_add = k.fa; sec_add = k.sa; dbg_sel = k.dbg;
    add_sel = k.add_sel; mux_sel = k.mux_sel; pc_id = k.pc_id; pc_inc = k.pc_inc;
    pc_sel = k.pc_sel; ir_id = k.ir_id; mem_wr = k.mem_wr; reg_wr = k.reg_wr; opcode = k.op;
    a = m_rf[k.fa];
    b = m_rf[k.sa];
    alu_model(a, b, int'(k.op), res, c);
    addr    = k.add_sel ? a : m_pc;
    e.ir    = 16'(m_ir);
    e.addr  = 16'(addr);
    e.wdata = 16'(b);
    e.we    = k.mem_wr;
    e.dbg   = 16'(m_rf[k.dbg]);
    e.n     = (res >= 32768);
    e.z     = (res == 0);
    e.c     = c;
    if (chk) exp_q.push_back(e);
    rdata = m_mem[addr];
    if (k.mem_wr) m_mem[addr] = b;
    if (k.rst) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_pc = 0;
      m_ir = 0;
    end else begin
      if (k.reg_wr) m_rf[k.wa] = k.mux_sel ? rdata : res;
      if (k.pc_id) m_pc = k.pc_sel ? b : (m_pc + 1) % 65536;
      else if (k.pc_inc) m_pc = (m_pc + 1) % 65536;
      if (k.ir_id) m_ir = rdata;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t idle(input int d);
    ctl_t k;
    k = '{default: '0};
    k.dbg = 3'(d);
    return k;
  endfunction

  task automatic poke_mem(input int unsigned addr, input logic [15:0] val);
    mem[addr]   = val;
    m_mem[addr] = int'(val);
  endtask

  // Load a register from memory at the current PC
  task automatic set_reg(input int idx, input logic [15:0] val);
    ctl_t k;
    poke_mem(m_pc, val);
    k = idle(idx);
    k.reg_wr = 1'b1; k.mux_sel = 1'b1; k.wa = 3'(idx);
    cycle(k, 1'b1);
  endtask

  task automatic alu_op(input int op, input logic [15:0] x, input logic [15:0] y);
    ctl_t k;
    set_reg(1, x);
    set_reg(2, y);
    k = idle(7);
    k.op = 4'(op); k.fa = 3'd1; k.sa = 3'd2; k.reg_wr = 1'b1; k.wa = 3'd7;
    cycle(k, 1'b1);
    cycle(idle(7), 1'b1);
  endtask

  task automatic jump_via(input int idx);
    ctl_t k;
    k = idle(idx);
    k.pc_id = 1'b1; k.pc_sel = 1'b1; k.sa = 3'(idx);
    cycle(k, 1'b1);
  endtask

  initial begin
    ctl_t k;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      mem[i]   = v;
      m_mem[i] = int'(v);
    end

    // Reset held two cycles against active enables
    k = idle(0);
    k.rst = 1'b1; k.reg_wr = 1'b1; k.pc_id = 1'b1; k.ir_id = 1'b1; k.wa = 3'd3;
    cycle(k, 1'b0);
    cycle(k, 1'b1);
    for (int i = 0; i < 8; i++) cycle(idle(i), 1'b1);

    // Fetch from address 0
    poke_mem(0, 16'h4053);
    k = idle(0); k.pc_id = 1'b1; k.ir_id = 1'b1;
    cycle(k, 1'b1);
    cycle(idle(0), 1'b1);

    // Fetch at 16'hFFFF wraps PC to 0
    set_reg(6, 16'hFFFF);
    jump_via(6);
    k = idle(0); k.pc_id = 1'b1; k.ir_id = 1'b1;
    cycle(k, 1'b1);
    cycle(idle(0), 1'b1);

    alu_op(0, 16'h8000, 16'h8000);
    alu_op(1, 16'h0003, 16'h0005);
    alu_op(2, 16'h0100, 16'h0100);
    alu_op(3, 16'h0007, 16'h0000);
    alu_op(3, 16'h0007, 16'h0002);
    alu_op(4, 16'hFFFF, 16'h1234);
    alu_op(5, 16'h0000, 16'h1234);
    alu_op(9, 16'h00FF, 16'h0000);
    alu_op(12, 16'h8001, 16'h7777);

    // Same-cycle read of a register being written returns the old value
    set_reg(3, 16'd9);
    k = idle(3); k.reg_wr = 1'b1; k.wa = 3'd3; k.op = 4'd4; k.fa = 3'd3; k.add_sel = 1'b1;
    cycle(k, 1'b1);
    cycle(idle(3), 1'b1);

    // Store R0 to [R4], then load it back into R5
    set_reg(4, 16'h0020);
    set_reg(0, 16'hBEEF);
    k = idle(0); k.mem_wr = 1'b1; k.add_sel = 1'b1; k.fa = 3'd4; k.sa = 3'd0;
    cycle(k, 1'b1);
    k = idle(5); k.reg_wr = 1'b1; k.mux_sel = 1'b1; k.add_sel = 1'b1; k.fa = 3'd4; k.wa = 3'd5;
    cycle(k, 1'b1);
    cycle(idle(5), 1'b1);

    // Jump, then the same jump with reset asserted mid-op
    set_reg(6, 16'h0100);
    jump_via(6);
    cycle(idle(0), 1'b1);
    k = idle(1); k.rst = 1'b1; k.pc_id = 1'b1; k.pc_sel = 1'b1; k.sa = 3'd6;
    k.reg_wr = 1'b1; k.wa = 3'd1;
    cycle(k, 1'b1);
    cycle(idle(1), 1'b1);
    cycle(idle(6), 1'b1);

    // Random control words
    for (int i = 0; i < 600; i++) begin
      k.rst     = ($urandom_range(0, 49) == 0);
      k.wa      = 3'($urandom);
      k.fa      = 3'($urandom);
      k.sa      = 3'($urandom);
      k.dbg     = 3'($urandom);
      k.add_sel = 1'($urandom);
      k.mux_sel = 1'($urandom);
      k.pc_id   = 1'($urandom);
      k.pc_inc  = 1'($urandom);
      k.pc_sel  = 1'($urandom);
      k.ir_id   = 1'($urandom);
      k.mem_wr  = ($urandom_range(0, 3) == 0);
      k.reg_wr  = 1'($urandom);
      k.op      = 4'($urandom);
      cycle(k, 1'b1);
    end

    cycle(idle(0), 1'b0);
    @(negedge clk);
    #1;
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Execution datapath driven by the 16-bit processor's control unit. It consumes the control unit's per-state control word and returns IR and the live N/Z/C flags.
- Contains the 8x16 register file, PC, IR, a single-cycle ALU and the address/write-back muxes.
- Talks to an external unified instruction/data memory with asynchronous read and synchronous write.

Parameters:
- DATA_W, 16, datapath and instruction width.
- AW, 16, memory address width. PC width equals AW.
- PC_RESET, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- write_add  in  3  register file write address
- fir_add  in  3  register file read port A address
- sec_add  in  3  register file read port B address
- add_sel  in  1  memory address select: 0 = PC, 1 = R[fir_add]
- mux_sel  in  1  write-back select: 0 = ALU result, 1 = mem_rdata
- pc_id  in  1  PC update enable
- pc_inc  in  1  PC increment request when pc_id=0
- pc_sel  in  1  PC source when pc_id=1: 0 = PC+1, 1 = R[sec_add]
- ir_id  in  1  IR load enable
- mem_wr  in  1  memory write request
- reg_wr  in  1  register file write enable
- opcode  in  4  ALU operation
- IR  out  16  instruction register
- N  out  1  negative flag, combinational
- Z  out  1  zero flag, combinational
- C  out  1  carry/overflow flag, combinational
- mem_addr  out  AW  memory address
- mem_wdata  out  16  memory write data, equal to R[sec_add]
- mem_we  out  1  memory write strobe, equal to mem_wr
- mem_rdata  in  16  memory read data, valid combinationally for mem_addr
- dbg_sel  in  3  debug register select
- dbg_data  out  16  R[dbg_sel], combinational

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - R0..R7 = 0, PC = PC_RESET, IR = 0.
  - Combinational outputs then follow from the reset state: mem_addr = PC_RESET when add_sel=0, mem_we = mem_wr.
  - Reset overrides every enable in the same cycle, including mid-instruction.
- Read ports: A = R[fir_add], B = R[sec_add]. Reads are asynchronous. A read of a register being written in the same cycle returns the old value (no bypass).
- Memory address: mem_addr = add_sel ? A[AW-1:0] : PC.
- Write-back: when reg_wr=1, at the clock edge R[write_add] <= mux_sel ? mem_rdata : alu_res. All 8 registers are writable.
- ALU, combinational on A and B. Flags are driven every cycle; the control unit decides when to capture them.
  - 0000 ADD: res = A+B; C = carry out of bit 15.
  - 0001 SUB: res = A-B; C = borrow (1 when A<B unsigned).
  - 0010 MUL: res = low 16 bits of A*B (unsigned); C = 1 when the upper 16 bits are nonzero.
  - 0011 DIV: res = A/B (unsigned). If B=0: res = 16'hFFFF, C = 1. Otherwise C = 0.
  - 0100 INC: res = A+1; C = carry out, so A=16'hFFFF gives res 0, C=1.
  - 0101 DEC: res = A-1; C = borrow, so A=0 gives res 16'hFFFF, C=1.
  - 0110 AND: A&B. 0111 OR: A|B. 1000 XOR: A^B. 1001 NOT: ~A. C = 0 for all four.
  - 1010, 1011, 1100-1111: res = A (pass-through); C = 0.
  - For every opcode: N = res[15], Z = (res == 0).
- PC update at the clock edge, in priority order:
  1. rst.
  2. pc_id=1 and pc_sel=1: PC <= B[AW-1:0].
  3. pc_id=1 and pc_sel=0: PC <= PC+1, wrapping 16'hFFFF -> 0.
  4. pc_inc=1: PC <= PC+1.
  5. Otherwise PC holds.
- IR: when ir_id=1, IR <= mem_rdata at the edge, using the pre-edge mem_addr.
- Fetch cycle (pc_id=1, ir_id=1, add_sel=0): IR gets mem[PC_old] and PC becomes PC_old+1 in the same edge.
- Memory write: mem_we = mem_wr, with address mem_addr and data mem_wdata = B. The write itself happens in the external memory on the same edge.
- Simultaneous reg_wr and mem_wr: both occur. A register written in that cycle does not affect that cycle's mem_wdata or mem_addr.
- Latency:
  - ALU result and flags: 0 cycles (combinational).
  - Register, PC and IR updates: visible 1 cycle after the enabling edge.

Test Plan:
- Reset: hold rst 2 cycles while driving reg_wr=1, pc_id=1, ir_id=1 -> PC=0, IR=0, dbg_data=0 for all dbg_sel.
- Fetch: mem[0]=16'h4053, assert pc_id=1, ir_id=1, add_sel=0 for one cycle -> IR=16'h4053, PC=1. At PC=16'hFFFF, a fetch wraps PC to 0.
- ALU and flags:
  - R1=16'h8000, R2=16'h8000, ADD -> res 0, Z=1, C=1, N=0.
  - SUB R1=3, R2=5 -> res 16'hFFFE, N=1, C=1.
  - MUL 16'h0100*16'h0100 -> res 0, C=1, Z=1.
  - DIV 7/0 -> res 16'hFFFF, C=1.
  - DIV 7/2 -> res 3, C=0.
- Write-back and read hazard: reg_wr=1, write_add=3, opcode INC, fir_add=3 with R3=9 -> same-cycle A reads 9; next cycle R3=10.
- Load/store: R4=16'h0020, R0=16'hBEEF; mem_wr=1, add_sel=1, fir_add=4, sec_add=0 -> mem[16'h20]=16'hBEEF. Then reg_wr=1, mux_sel=1, add_sel=1, fir_add=4, write_add=5 -> R5=16'hBEEF.
- Jump and reset mid-op: R6=16'h0100, pc_id=1, pc_sel=1, sec_add=6 -> PC=16'h0100. Repeat with rst=1 in the same cycle -> PC=0, and no register is written.
